// File: rtl/sram_like_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, grant codes and size codes.
package sram_like_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter.sv
// Merges the core's inst and data SRAM-like channels onto one bus, one transaction at a time.
// Data wins arbitration unless inst has been held off for STARVE_LIMIT consecutive data grants.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          addr_hit, data_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= GNT_INST;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    starve_cnt_d = starve_cnt_q;
    addr_hit     = 1'b0;
    data_hit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req && (!inst_req || starve_cnt_q < LIMIT)) begin
          grant_d      = GNT_DATA;
          state_d      = S_ADDR;
          // counts only grants that actually made inst wait
          if (!inst_req)                 starve_cnt_d = '0;
          else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (inst_req) begin
          grant_d      = GNT_INST;
          state_d      = S_ADDR;
          starve_cnt_d = '0;
        end
      end
      S_ADDR: begin
        if (bus_addr_ok) begin
          addr_hit = 1'b1;
          if (bus_data_ok) begin
            data_hit = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus_data_ok) begin
          data_hit = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // request mux: fields are only meaningful while the address phase is open
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (state_q == S_ADDR && !rst) begin
      bus_req = 1'b1;
      if (grant_q == GNT_DATA) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
      end
    end
  end

  always_comb begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (!rst) begin
      if (grant_q == GNT_DATA) begin
        data_addr_ok = addr_hit;
        data_data_ok = data_hit;
        data_rdata   = data_hit ? bus_rdata : '0;
      end else begin
        inst_addr_ok = addr_hit;
        inst_data_ok = data_hit;
        inst_rdata   = data_hit ? bus_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: expected bus transactions queued at stimulus time,
// popped and compared as the bench plays the downstream slave.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, bus_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        chan;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t exp_q[$];

  sram_like_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic chan, input logic wr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.chan = chan; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  // Act as the slave for one transaction: wait for bus_req, compare, then respond.
  task automatic serve(input bit keep, input bit same, input int hold);
    txn_t e;
    int   n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("bus_req_wait", bus_req, 1);
    chk("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int k = 0; k <= hold; k++) begin
      chk("bus_req_hold", bus_req, 1);
      chk("bus_wr", bus_wr, e.wr);
      chk("bus_size", bus_size, e.size);
      chk("bus_addr", bus_addr, e.addr);
      chk("bus_wdata", bus_wdata, e.wdata);
      if (k < hold) step();
    end
    bus_addr_ok = 1'b1;
    if (same) begin
      bus_data_ok = 1'b1;
      bus_rdata   = e.rdata;
    end
    #1;
    chk("inst_addr_ok", inst_addr_ok, e.chan == GNT_INST);
    chk("data_addr_ok", data_addr_ok, e.chan == GNT_DATA);
    if (same) begin
      chk("inst_data_ok_same", inst_data_ok, e.chan == GNT_INST);
      chk("data_data_ok_same", data_data_ok, e.chan == GNT_DATA);
      chk("inst_rdata_same", inst_rdata, (e.chan == GNT_INST) ? e.rdata : 32'h0);
      chk("data_rdata_same", data_rdata, (e.chan == GNT_DATA) ? e.rdata : 32'h0);
    end
    step();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    if (!keep) begin
      if (e.chan == GNT_INST) inst_req = 1'b0;
      else                    data_req = 1'b0;
    end
    #1;
    chk("bus_req_after_addr", bus_req, 0);
    if (same) begin
      chk("state_idle_same", 32'(dut.state_q), 32'(S_IDLE));
    end else begin
      chk("inst_data_ok_early", inst_data_ok, 0);
      chk("data_data_ok_early", data_data_ok, 0);
      bus_data_ok = 1'b1;
      bus_rdata   = e.rdata;
      #1;
      chk("inst_data_ok", inst_data_ok, e.chan == GNT_INST);
      chk("data_data_ok", data_data_ok, e.chan == GNT_DATA);
      chk("inst_rdata", inst_rdata, (e.chan == GNT_INST) ? e.rdata : 32'h0);
      chk("data_rdata", data_rdata, (e.chan == GNT_DATA) ? e.rdata : 32'h0);
      step();
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SZ_WORD; data_addr = '0; data_wdata = '0;
    bus_rdata = '0; bus_addr_ok = 0; bus_data_ok = 0;

    // reset: outputs forced low even with live inputs
    step();
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    step();
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    rst = 0;
    step();
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("rst_grant", 32'(dut.grant_q), 32'(GNT_INST));
    chk("rst_starve", 32'(dut.starve_cnt_q), 0);
    chk("rst_bus_req_after", bus_req, 0);

    // stray slave handshakes in IDLE are ignored
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
    #1;
    chk("idle_inst_data_ok", inst_data_ok, 0);
    chk("idle_data_data_ok", data_data_ok, 0);
    chk("idle_inst_rdata", inst_rdata, 0);
    chk("idle_data_addr_ok", data_addr_ok, 0);
    step();
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    chk("idle_stays", 32'(dut.state_q), 32'(S_IDLE));

    // 1: single inst fetch, one-cycle request latency
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = SZ_WORD;
    push(GNT_INST, 0, SZ_WORD, 32'hBFC0_0000, 32'h0, 32'h3C1D_0000);
    #1;
    chk("t1_bus_req_n", bus_req, 0);
    step();
    chk("t1_bus_req_n1", bus_req, 1);
    serve(0, 0, 0);

    // 2: simultaneous requests, data first
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_size = SZ_WORD; data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
    push(GNT_DATA, 1, SZ_WORD, 32'h8000_1000, 32'h1234_5678, 32'h0);
    push(GNT_INST, 0, SZ_WORD, 32'hBFC0_0004, 32'h0, 32'h2410_0001);
    serve(0, 0, 0);
    serve(0, 0, 0);

    // 3: starvation bound
    inst_req = 1; inst_addr = 32'hBFC0_0008;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_2000; data_wdata = 32'h0;
    for (int i = 0; i < 4; i++) push(GNT_DATA, 0, SZ_WORD, 32'h8000_2000, 32'h0, 32'hD000_0000 + i);
    push(GNT_INST, 0, SZ_WORD, 32'hBFC0_0008, 32'h0, 32'h0000_0008);
    push(GNT_DATA, 0, SZ_WORD, 32'h8000_2000, 32'h0, 32'hD000_0004);
    for (int i = 0; i < 4; i++) serve(1, 0, 0);
    chk("t3_starve_sat", 32'(dut.starve_cnt_q), 4);
    serve(0, 0, 0);
    chk("t3_starve_clr", 32'(dut.starve_cnt_q), 0);
    serve(0, 0, 0);
    chk("t3_starve_end", 32'(dut.starve_cnt_q), 0);

    // 4: addr_ok and data_ok in the same cycle
    data_req = 1; data_wr = 0; data_addr = 32'h8000_3000;
    push(GNT_DATA, 0, SZ_WORD, 32'h8000_3000, 32'h0, 32'hCAFE_F00D);
    serve(0, 1, 0);

    // 6: byte write, fields held while slave stalls
    data_req = 1; data_wr = 1; data_size = SZ_BYTE; data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
    push(GNT_DATA, 1, SZ_BYTE, 32'h8000_0003, 32'h0000_00AB, 32'h0);
    serve(0, 0, 2);

    // 5: reset with a data write outstanding
    data_req = 1; data_wr = 1; data_size = SZ_WORD; data_addr = 32'h8000_4000; data_wdata = 32'h55;
    n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t5_bus_req", bus_req, 1);
    chk("t5_bus_addr", bus_addr, 32'h8000_4000);
    bus_addr_ok = 1;
    #1;
    chk("t5_data_addr_ok", data_addr_ok, 1);
    step();
    bus_addr_ok = 0; data_req = 0;
    chk("t5_in_data", 32'(dut.state_q), 32'(S_DATA));
    rst = 1; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t5_rst_data_ok", data_data_ok, 0);
    chk("t5_rst_rdata", data_rdata, 0);
    step();
    rst = 0;
    #1;
    chk("t5_state_idle", 32'(dut.state_q), 32'(S_IDLE));
    chk("t5_bus_req_low", bus_req, 0);
    chk("t5_late_data_ok", data_data_ok, 0);
    chk("t5_late_rdata", data_rdata, 0);
    step();
    bus_data_ok = 0; bus_rdata = '0;
    chk("t5_still_idle", bus_req, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
